// File: rtl/memory_pipe.sv
// memory_pipe -- Y86-64 memory stage: M pipeline register, data memory, W pipeline register.
//
// The M register captures the execute-stage outputs (e_*). While an instruction
// sits in M, the data memory is accessed: loads (mrmovq, ret, popq) read
// combinationally into m_valM, stores (rmmovq, call, pushq) commit at the next
// rising edge. The W register then captures the memory-stage results.
//
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset (pipeline registers only)
//   M_bubble            load a bubble into M at the next edge
//   W_stall             hold M and W, suppress the memory write
//   e_stat..e_dstM      execute-stage outputs
//   M_*                 M register contents (for forwarding / hazard logic)
//   m_stat, m_valM      memory-stage status and load data (combinational)
//   W_*                 W register contents
//
// Build option:
//   MEM_ALIGN_CHECK_EN  when defined, any access with addr[2:0] != 0 is treated
//                       as an invalid address (ADR status, no write, m_valM = 0).
//                       When undefined, unaligned 8-byte accesses are byte-granular.
module memory_pipe #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_bubble,
  input  logic        W_stall,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [3:0]  m_stat,
  output logic [63:0] m_valM,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [3:0] S_AOK    = 4'd8;
  localparam logic [3:0] S_ADR    = 4'd2;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_CMOV   = 4'd2;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;
  localparam logic [3:0] R_NONE   = 4'd15;

  // Highest legal start address of an 8-byte access.
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

  // Byte-wide data memory; deliberately not reset.
  logic [7:0] mem [MEM_BYTES];

  logic          mem_read;
  logic          mem_write;
  logic [63:0]   addr;
  logic          addr_ok;
  logic          wr_en;
  logic [AW-1:0] base;
  logic [63:0]   rd_word;
  logic [3:0]    m_dste_in;

  always_comb begin
    mem_read  = (M_icode == I_MRMOVQ) || (M_icode == I_RET) || (M_icode == I_POPQ);
    mem_write = (M_icode == I_RMMOVQ) || (M_icode == I_CALL) || (M_icode == I_PUSHQ);
    // ret/popq read through the old stack pointer carried in valA.
    addr      = ((M_icode == I_RET) || (M_icode == I_POPQ)) ? M_valA : M_valE;
`ifdef MEM_ALIGN_CHECK_EN
    addr_ok   = (addr <= LAST_ADDR) && (addr[2:0] == 3'd0);
`else
    addr_ok   = (addr <= LAST_ADDR);
`endif
    base      = addr[AW-1:0];
    m_stat    = ((mem_read || mem_write) && !addr_ok && (M_stat == S_AOK)) ? S_ADR : M_stat;
    // Never commit a store behind a faulted instruction already in W,
    // while stalled, or while reset is asserted.
    wr_en     = mem_write && addr_ok && (M_stat == S_AOK) && !W_stall &&
                (W_stat == S_AOK) && rst_n;
    m_valM    = (mem_read && addr_ok) ? rd_word : 64'd0;
    // A not-taken conditional move writes no register.
    m_dste_in = ((e_icode == I_CMOV) && !e_cnd) ? R_NONE : e_dstE;
  end

  // Little-endian byte gather; base+gi stays in range whenever addr_ok.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rd
      assign rd_word[8*gi +: 8] = mem[base + AW'(gi)];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= M_valA[8*i +: 8];
      end
    end
  end

  // M register: stall holds, bubble inserts a nop, otherwise capture e_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_stat  <= S_AOK;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= 64'd0;
      M_valA  <= 64'd0;
      M_dstE  <= R_NONE;
      M_dstM  <= R_NONE;
    end else if (W_stall) begin
      M_stat  <= M_stat;
    end else if (M_bubble) begin
      M_stat  <= S_AOK;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= 64'd0;
      M_valA  <= 64'd0;
      M_dstE  <= R_NONE;
      M_dstM  <= R_NONE;
    end else begin
      M_stat  <= e_stat;
      M_icode <= e_icode;
      M_cnd   <= e_cnd;
      M_valE  <= e_valE;
      M_valA  <= e_valA;
      M_dstE  <= m_dste_in;
      M_dstM  <= e_dstM;
    end
  end

  // W register: captures memory-stage results unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      W_stat  <= S_AOK;
      W_icode <= I_NOP;
      W_valE  <= 64'd0;
      W_valM  <= 64'd0;
      W_dstE  <= R_NONE;
      W_dstM  <= R_NONE;
    end else if (!W_stall) begin
      W_stat  <= m_stat;
      W_icode <= M_icode;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
    end
  end

endmodule
